// File: rtl/hdlc_tx_channel.sv
`default_nettype none
// ==== hdlc_tx_channel -- HDLC serial transmitter: flags, zero insertion, CRC-16 FCS, abort | rev 1.0 ====
module hdlc_tx_channel #(
  parameter bit FCS_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_FCS   = 3'd3,
    S_END   = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [7:0]  C_FLAG  = 8'h7E;
  localparam logic [7:0]  C_ABORT = 8'hFE;
  localparam logic [15:0] C_POLY  = 16'h8005;

  state_t      state_q, state_d;
  logic        tx_q, tx_d;
  logic        valid_q, valid_d;
  logic        rd_q, rd_d;
  logic        pend_q, pend_d;
  logic        aborted_q, aborted_d;
  logic        done_q, done_d;
  logic        full_q, full_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  ones_q, ones_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  hold_q, hold_d;

  logic [2:0]  w_nxt;
  logic        w_have;
  logic [7:0]  w_byte;
  logic [2:0]  w_ones_base;
  logic        w_fcs_bit;
  logic        w_busy;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? C_POLY : 16'h0000);
  endfunction

  // A read arriving this very edge counts as a held byte, so the frame never gaps.
  assign w_nxt       = cnt_q[2:0] + 3'd1;
  assign w_have      = full_q | pend_q;
  assign w_byte      = full_q ? hold_q : Tx_Data;
  assign w_ones_base = (state_q == S_DATA) ? ones_q : 3'd0;
  assign w_fcs_bit   = crc_q[4'd14 - cnt_q];
  assign w_busy      = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_FCS)   || (state_q == S_END);

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    pend_d    = rd_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    full_d    = full_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    crc_d     = crc_q;
    cur_d     = cur_q;
    hold_d    = hold_q;

    if (pend_q) begin
      hold_d = Tx_Data;
      full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (Tx_Enable && Tx_DataAvail) begin
          state_d   = S_START;
          cnt_d     = 4'd0;
          tx_d      = C_FLAG[0];
          aborted_d = 1'b0;
          crc_d     = 16'h0000;
          ones_d    = 3'd0;
          full_d    = 1'b0;
          pend_d    = 1'b0;
        end
      end
      S_START, S_DATA: begin
        if (state_q == S_DATA && ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if (cnt_q[2:0] != 3'd7) begin
          cnt_d = cnt_q + 4'd1;
          if (state_q == S_START) begin
            tx_d = C_FLAG[w_nxt];
          end else begin
            tx_d   = cur_q[w_nxt];
            crc_d  = crc_step(crc_q, cur_q[w_nxt]);
            ones_d = cur_q[w_nxt] ? ones_q + 3'd1 : 3'd0;
          end
        end else if (w_have) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
          cur_d   = w_byte;
          full_d  = 1'b0;
          tx_d    = w_byte[0];
          crc_d   = crc_step(crc_q, w_byte[0]);
          ones_d  = w_byte[0] ? w_ones_base + 3'd1 : 3'd0;
        end else if (FCS_EN) begin
          state_d = S_FCS;
          cnt_d   = 4'd0;
          tx_d    = crc_q[15];
          ones_d  = crc_q[15] ? w_ones_base + 3'd1 : 3'd0;
        end else begin
          state_d = S_END;
          cnt_d   = 4'd0;
          tx_d    = C_FLAG[0];
        end
      end
      S_FCS: begin
        if (ones_q == 3'd5) begin
          tx_d   = 1'b0;
          ones_d = 3'd0;
        end else if (cnt_q != 4'd15) begin
          cnt_d  = cnt_q + 4'd1;
          tx_d   = w_fcs_bit;
          ones_d = w_fcs_bit ? ones_q + 3'd1 : 3'd0;
        end else begin
          state_d = S_END;
          cnt_d   = 4'd0;
          tx_d    = C_FLAG[0];
        end
      end
      S_END: begin
        if (cnt_q[2:0] != 3'd7) begin
          cnt_d = cnt_q + 4'd1;
          tx_d  = C_FLAG[w_nxt];
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_ABORT: begin
        if (cnt_q[2:0] != 3'd7) begin
          cnt_d = cnt_q + 4'd1;
          tx_d  = C_ABORT[w_nxt];
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Abort drops the held byte and any read still in flight.
    if (Tx_AbortFrame && w_busy) begin
      state_d   = S_ABORT;
      cnt_d     = 4'd0;
      tx_d      = C_ABORT[0];
      aborted_d = 1'b1;
      full_d    = 1'b0;
      pend_d    = 1'b0;
      ones_d    = 3'd0;
    end

    valid_d = (state_d == S_START) || (state_d == S_DATA) ||
              (state_d == S_FCS)   || (state_d == S_END);
    rd_d    = ((state_d == S_START) || (state_d == S_DATA)) && !full_d &&
              Tx_DataAvail && !rd_q && !pend_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      valid_q   <= 1'b0;
      rd_q      <= 1'b0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      cnt_q     <= 4'd0;
      ones_q    <= 3'd0;
      crc_q     <= 16'h0000;
      cur_q     <= 8'h00;
      hold_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      crc_q     <= crc_d;
      cur_q     <= cur_d;
      hold_q    <= hold_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_RdBuff       = rd_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx_Done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_tx_channel.sv
`default_nettype none
// ==== tb_hdlc_tx_channel -- randomized bench with frame-level reference model | rev 1.0 ====
module tb_hdlc_tx_channel;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [1:0]      en, ab, avail, rd, tx, valid, aborted, done;
  logic [1:0][7:0] data;

  logic [7:0] mem [2][64];
  int         rdp [2];
  int         wrp [2];
  int         rdcnt [2];
  logic [1:0] prev_rd;
  logic [1:0] ab_st;
  logic [7:0] frame [64];
  bit         exp_q [$];
  bit         obs_q [$];
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 Clk = ~Clk;

  // Unit 0 sends no FCS, unit 1 appends the CRC-16.
  hdlc_tx_channel #(.FCS_EN(1'b0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(en[0]), .Tx_AbortFrame(ab[0]),
    .Tx_DataAvail(avail[0]), .Tx_Data(data[0]), .Tx_RdBuff(rd[0]), .Tx(tx[0]),
    .Tx_ValidFrame(valid[0]), .Tx_AbortedTrans(aborted[0]), .Tx_Done(done[0])
  );

  hdlc_tx_channel #(.FCS_EN(1'b1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(en[1]), .Tx_AbortFrame(ab[1]),
    .Tx_DataAvail(avail[1]), .Tx_Data(data[1]), .Tx_RdBuff(rd[1]), .Tx(tx[1]),
    .Tx_ValidFrame(valid[1]), .Tx_AbortedTrans(aborted[1]), .Tx_Done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, expv, $time);
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
  endfunction

  // Whole-frame expectation: flag, stuffed(data LSB-first [+ FCS MSB-first]), flag.
  function automatic void build_exp(input bit fcs, input int n);
    bit         pay [$];
    logic [15:0] crc;
    logic [7:0]  flag;
    int          ones;
    flag = 8'h7E;
    crc  = 16'h0000;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(flag[k]);
    for (int j = 0; j < n; j++)
      for (int k = 0; k < 8; k++) begin
        pay.push_back(frame[j][k]);
        crc = lfsr(crc, frame[j][k]);
      end
    if (fcs) for (int k = 15; k >= 0; k--) pay.push_back(crc[k]);
    ones = 0;
    foreach (pay[k]) begin
      exp_q.push_back(pay[k]);
      ones = pay[k] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(flag[k]);
  endfunction

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_gap%0d", i), 32'(rd[i] & prev_rd[i]), 32'd0);
      prev_rd[i] = rd[i];
      if (rd[i] === 1'b1) begin
        data[i] = (rdp[i] < wrp[i]) ? mem[i][rdp[i]] : 8'h00;
        rdp[i]++;
        rdcnt[i]++;
      end
      avail[i] = (rdp[i] < wrp[i]);
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("idle_tx%0d", i), 32'(tx[i]), 32'd1);
        chk($sformatf("idle_valid%0d", i), 32'(valid[i]), 32'd0);
        chk($sformatf("idle_done%0d", i), 32'(done[i]), 32'd0);
        chk($sformatf("idle_aborted%0d", i), 32'(aborted[i]), 32'(ab_st[i]));
      end
    end
  endtask

  task automatic fill_rand(input int n);
    for (int j = 0; j < n; j++) frame[j] = 8'($urandom);
  endtask

  task automatic load_buf(input int i, input int n);
    for (int j = 0; j < n; j++) mem[i][j] = frame[j];
    rdp[i]   = 0;
    wrp[i]   = n;
    rdcnt[i] = 0;
    avail[i] = (n > 0);
  endtask

  // Receiver view: destuff the bits between the flags and run the same LFSR.
  task automatic rx_check(input int n);
    logic [15:0] crc;
    int          ones, cnt;
    bit          skip;
    crc = 16'h0000; ones = 0; cnt = 0; skip = 1'b0;
    for (int k = 8; k < obs_q.size() - 8; k++) begin
      if (skip) begin
        chk("stuffed_bit", 32'(obs_q[k]), 32'd0);
        skip = 1'b0;
        continue;
      end
      crc  = lfsr(crc, obs_q[k]);
      cnt++;
      ones = obs_q[k] ? ones + 1 : 0;
      if (ones == 5) begin
        skip = 1'b1;
        ones = 0;
      end
    end
    chk("fcs_residue", 32'(crc), 32'd0);
    chk("rx_bit_count", 32'(cnt), 32'(n * 8 + 16));
  endtask

  // ab_mode: 0 none, >0 abort sampled in that cycle, <0 random abort cycle.
  task automatic run_frame(input int i, input int n, input int ab_mode,
                           input bit ab_with_en, input bit rnd_en);
    int len, last, ab_cyc, etx, ev, ea, ed;
    load_buf(i, n);
    build_exp(i == 1, n);
    len    = exp_q.size();
    ab_cyc = (ab_mode < 0) ? int'($urandom_range(1, len)) : ab_mode;
    last   = (ab_cyc > 0) ? ab_cyc + 9 : len + 1;
    obs_q.delete();
    en[i] = 1'b1;
    ab[i] = ab_with_en;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (ab_cyc > 0 && c > ab_cyc) begin
        etx = (c == ab_cyc + 1) ? 0 : 1; ev = 0; ea = 1; ed = 0;
      end else if (c <= len) begin
        etx = int'(exp_q[c-1]); ev = 1; ea = 0; ed = 0;
      end else begin
        etx = 1; ev = 0; ea = 0; ed = 1;
      end
      chk($sformatf("tx%0d_c%0d", i, c), 32'(tx[i]), 32'(etx));
      chk($sformatf("valid%0d_c%0d", i, c), 32'(valid[i]), 32'(ev));
      chk($sformatf("aborted%0d_c%0d", i, c), 32'(aborted[i]), 32'(ea));
      chk($sformatf("done%0d_c%0d", i, c), 32'(done[i]), 32'(ed));
      if (c <= len) obs_q.push_back(tx[i]);
      en[i] = (rnd_en && c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      ab[i] = (ab_cyc > 0 && c == ab_cyc);
    end
    if (ab_cyc > 0) begin
      rdp[i]   = wrp[i];
      avail[i] = 1'b0;
      ab_st[i] = 1'b1;
    end else begin
      ab_st[i] = 1'b0;
      chk($sformatf("rd_count%0d", i), 32'(rdcnt[i]), 32'(n));
      if (i == 1) rx_check(n);
    end
  endtask

  initial begin
    int sel, nb;
    Rst = 1'b1; en = '0; ab = '0; avail = '0; data = '0; prev_rd = '0; ab_st = '0;
    for (int i = 0; i < 2; i++) begin
      rdp[i] = 0; wrp[i] = 0; rdcnt[i] = 0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'd1);
      chk($sformatf("rst_valid%0d", i), 32'(valid[i]), 32'd0);
      chk($sformatf("rst_rd%0d", i), 32'(rd[i]), 32'd0);
      chk($sformatf("rst_aborted%0d", i), 32'(aborted[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
    end
    Rst = 1'b0;
    idle(2);

    frame[0] = 8'h01; run_frame(0, 1, 0, 1'b0, 1'b0);
    idle(2);
    frame[0] = 8'hFF; run_frame(0, 1, 0, 1'b0, 1'b0);
    idle(2);
    frame[0] = 8'h00; run_frame(1, 1, 0, 1'b0, 1'b0);
    idle(2);
    fill_rand(20); run_frame(1, 20, 0, 1'b0, 1'b1);
    idle(2);
    fill_rand(4); run_frame(1, 4, 11, 1'b0, 1'b0);
    idle(3);

    en = 2'b11;
    idle(4);
    en = 2'b00;
    idle(1);

    fill_rand(4); load_buf(0, 4);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    for (int c = 2; c <= 12; c++) tick();
    chk("pre_rst_valid0", 32'(valid[0]), 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_tx%0d", i), 32'(tx[i]), 32'd1);
      chk($sformatf("mid_rst_valid%0d", i), 32'(valid[i]), 32'd0);
      chk($sformatf("mid_rst_aborted%0d", i), 32'(aborted[i]), 32'd0);
      chk($sformatf("mid_rst_rd%0d", i), 32'(rd[i]), 32'd0);
    end
    rdp[0] = wrp[0]; avail[0] = 1'b0; ab_st = '0;
    idle(2);

    fill_rand(3); run_frame(1, 3, 0, 1'b1, 1'b0);
    idle(1);
    fill_rand(2); run_frame(0, 2, 0, 1'b0, 1'b1);
    fill_rand(3); run_frame(0, 3, 0, 1'b0, 1'b0);
    idle(2);

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 1));
      nb  = int'($urandom_range(1, 8));
      fill_rand(nb);
      run_frame(sel, nb, ($urandom_range(0, 2) == 0) ? -1 : 0, 1'b0, 1'b1);
      idle(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdlc_tx_channel.md
# hdlc_tx_channel

Serial transmit channel of the HDLC controller, the transmit counterpart of the Rx channel. It fetches frame bytes from the Tx buffer over a read-strobe handshake and serialises them LSB-first, one bit per clock, onto `Tx`. It generates the start and end flags, performs zero insertion, appends a CRC-16 FCS, and produces the abort and idle patterns. It sits between the Tx buffer/register block and the `Tx` pin.

## Interface
- `FCS_EN`, default 1: 1 appends a 16-bit FCS after the data; 0 goes straight from data to the end flag.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `Tx_Enable`  in  1  start-frame request; accepted only in IDLE with `Tx_DataAvail`=1.
- `Tx_AbortFrame`  in  1  abort request; acted on only while `Tx_ValidFrame`=1.
- `Tx_DataAvail`  in  1  Tx buffer holds at least one unread byte.
- `Tx_Data`  in  8  buffer read data; valid in the cycle after `Tx_RdBuff`.
- `Tx_RdBuff`  out  1  one-cycle read strobe to the Tx buffer.
- `Tx`  out  1  serial line, registered; idle level 1.
- `Tx_ValidFrame`  out  1  high from the first start-flag bit to the last end-flag bit.
- `Tx_AbortedTrans`  out  1  sticky; set on abort, cleared when the next frame is accepted.
- `Tx_Done`  out  1  one-cycle pulse after a frame completes normally.

## Operation
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- Flag is 0x7E, sent LSB-first as 0,1,1,1,1,1,1,0. Abort is 0,1,1,1,1,1,1,1.
- IDLE drives `Tx`=1 continuously.
- Holding register: one byte plus a full flag.
  - In START_FLAG or DATA, `Tx_RdBuff` pulses when the holding register is empty, `Tx_DataAvail`=1 and no read is outstanding.
  - `Tx_Data` is captured on the next edge.
- At the end of each flag or byte:
  - If holding is full, load the shift register from it and continue in DATA.
  - Otherwise go to FCS (`FCS_EN`=1) or END_FLAG (`FCS_EN`=0).
- Zero insertion, DATA and FCS only:
  - The ones counter is cleared on entry to DATA and by any transmitted 0.
  - After five consecutive 1s, one 0 is inserted before the next bit.
  - A stuffed 0 is not fed to the CRC and does not advance the bit index.
  - Flags and abort patterns are never stuffed.
- CRC-16:
  - `crc` is cleared to 0x0000 on frame accept.
  - For each unstuffed data bit b: fb = b ^ `crc[15]`; `crc` = {`crc[14:0]`,0} ^ (fb ? 0x8005 : 0).
  - In FCS, `crc[15]` down to `crc[0]` are sent, with stuffing.
  - A receiver running the same LFSR over data+FCS ends at 0x0000.
- END_FLAG: after the flag completes, return to IDLE and pulse `Tx_Done`.
- ABORT: send the 8-bit abort pattern, then return to IDLE. `Tx_Done` does not pulse.
- Boundary conditions:
  - `Tx_Enable` while not in IDLE, or with `Tx_DataAvail`=0: ignored.
  - `Tx_Enable` and `Tx_AbortFrame` together in IDLE: the frame starts and the abort is ignored.
  - `Tx_AbortFrame` in START_FLAG, DATA, FCS or END_FLAG: abort, and the holding byte is discarded.
  - A byte already read stays consumed.
  - `Tx_Enable` in the `Tx_Done` cycle is accepted, giving back-to-back frames.
  - `Rst` mid-frame: outputs take reset values on the next edge and no pattern completes.

## Timing
- Reset values: `Tx`=1, `Tx_ValidFrame`=0, `Tx_RdBuff`=0, `Tx_AbortedTrans`=0, `Tx_Done`=0; state IDLE; holding register empty.
- Frame start, with `Tx_Enable` sampled in cycle 0:
  - Cycles 1–8: start flag on `Tx`.
  - `Tx_ValidFrame`=1 from cycle 1.
  - First `Tx_RdBuff` in cycle 1; first data bit in cycle 9.
- Data bits are back-to-back; the only gaps are stuffed zeros.
- `Tx_Done` is high in the cycle after the last end-flag bit, and `Tx_ValidFrame`=0 in that cycle.
- Abort: `Tx_AbortFrame` sampled in cycle k gives:
  - `Tx`=0 in cycle k+1 and `Tx`=1 in cycles k+2..k+8.
  - `Tx_ValidFrame`=0 and `Tx_AbortedTrans`=1 from k+1.
  - IDLE from k+9.
- `Tx_RdBuff` never pulses in two consecutive cycles.

## Test plan
- `FCS_EN`=0, one byte 0x01, `Tx_Enable` in cycle 0 -> cycles 1–8 flag; cycles 9–16 1,0,0,0,0,0,0,0; cycles 17–24 flag; `Tx_Done` in cycle 25; exactly one `Tx_RdBuff`.
- `FCS_EN`=0, byte 0xFF -> cycles 9–17 1,1,1,1,1,0,1,1,1 (0 stuffed after bit 4); end flag in cycles 18–25; `Tx_Done` in cycle 26.
- `FCS_EN`=1, byte 0x00 -> 8 data zeros, then 16 FCS zeros in cycles 17–32, end flag in 33–40. A random 20-byte frame checked by a receiver LFSR gives residue 0x0000.
- `Tx_AbortFrame` in the 3rd data cycle of a 4-byte frame -> next 8 `Tx` bits are 0,1,1,1,1,1,1,1, then idle 1s; `Tx_AbortedTrans`=1 until the next accepted `Tx_Enable`; no `Tx_Done`.
- Two frames, second `Tx_Enable` in the `Tx_Done` cycle -> second start flag begins on the next cycle. `Tx_Enable` with `Tx_DataAvail`=0 -> no response.
- `Rst` in mid-data of a frame -> next cycle `Tx`=1, `Tx_ValidFrame`=0, `Tx_AbortedTrans`=0; a new frame then transmits correctly.
